ma_stage: RTL
=============

Name: ma_stage

Overview:
- Memory-access pipeline stage of the 32-bit RISC core. It sits between execute and the write-back stage, which is combinational and consumes its outputs every cycle.
- Takes the execute latch, performs load/store through a req/ack data-memory port with variable latency, and registers the results into the MA/WB latch.
- Stalls execute while a memory access is outstanding, and flags accesses that time out or are misaligned.

Parameters:
- MEM_TIMEOUT, 16: cycles spent waiting for Mem_Ack before the access is abandoned (legal range 1..255).
- ERR_LDDATA, 32'h0000_0000: LdResult value driven when a load times out.

Ports:
- Clk  in  1  core clock; all state updates on the rising edge.
- Rst_n  in  1  synchronous, active-low reset.
- In_Valid  in  1  execute latch holds a valid instruction.
- In_Ready  out  1  stage accepts an instruction this cycle; low means execute stalls.
- In_IsLd  in  1  instruction is a load.
- In_IsSt  in  1  instruction is a store.
- In_IsWb  in  1  instruction writes the register file.
- In_IsCall  in  1  instruction is a call (link into r15).
- In_Rd  in  4  destination register.
- In_AluResult  in  32  ALU result; effective address for load/store.
- In_Op2  in  32  store data.
- In_Pc  in  32  pc of the instruction.
- Mem_Req  out  1  data-memory request.
- Mem_We  out  1  request is a write.
- Mem_Addr  out  32  word address, bits [1:0] forced to 0.
- Mem_WData  out  32  store data.
- Mem_Ack  in  1  memory completed the request (one-cycle pulse).
- Mem_RData  in  32  load data, valid when Mem_Ack=1.
- Out_Valid  out  1  MA/WB latch holds a real instruction.
- IsWb, IsCall, IsLd  out  1 each  latched control bits for WB.
- Rd  out  4  latched destination register.
- AluResult  out  32  latched ALU result.
- LdResult  out  32  latched load data.
- pc_current  out  32  latched pc.
- Mem_Err  out  1  sticky error flag: timeout or misaligned address.

Behaviour:
Reset
- Clk with Rst_n=0: every output and internal register goes to 0, state goes to IDLE, Mem_Req=0 from the next cycle.
- A reset mid-access abandons the access. Any Mem_Ack after reset is ignored.

Bubbles
- When Out_Valid=0, IsWb, IsCall and IsLd are forced to 0, so WB never writes on a bubble.

States
- IDLE: In_Ready=1.
  - In_Valid=1 and neither In_IsLd nor In_IsSt: next cycle the latch holds the inputs, Out_Valid=1, LdResult=0. One-cycle latency, and back-to-back issue is sustained.
  - In_Valid=1 with In_IsLd or In_IsSt: capture all inputs into hold registers, present a bubble (Out_Valid=0), go to WAIT.
  - In_IsLd and In_IsSt both set: treated as a load; Mem_We=0.
  - In_Valid=0: bubble.
- WAIT: In_Ready=0.
  - Drive Mem_Req=1, Mem_We=held IsSt, Mem_Addr={held AluResult[31:2],2'b00}, Mem_WData=held Op2.
  - These stay stable until Mem_Ack is sampled.
  - A wait counter increments every WAIT cycle.
  - Mem_Ack=1: go to DONE; capture Mem_RData for a load, 0 for a store.
  - Counter reaches MEM_TIMEOUT with no ack: go to DONE, set Mem_Err, LdResult=ERR_LDDATA, held IsWb cleared.
  - Mem_Ack and timeout in the same cycle: the ack wins.
- DONE: one cycle.
  - Latch = held fields, Out_Valid=1, Mem_Req=0, In_Ready=1.
  - A new instruction may be accepted this same cycle, following the IDLE rules, so the next access can start without a dead cycle.
  - Then return to IDLE, or go to WAIT if a new memory instruction was accepted.

Memory port rules
- Mem_Ack seen in IDLE or DONE is ignored.
- Load latency = 2 + memory latency cycles, measured from acceptance to Out_Valid.
- Misaligned address (In_AluResult[1:0] != 0 on a load/store) sets Mem_Err at acceptance; the access still proceeds.
- Mem_Err clears only on reset.
- Call handling (r15 selection, pc+4) belongs to WB; this stage only forwards IsCall and pc_current unchanged.

Decomposition:
- Shared core package:
  - state enum IDLE/WAIT/DONE;
  - constant LINK_REG=4'd15;
  - WORD_W=32, REG_ADDR_W=4.
- Sub-module ma_wb_latch: the MA/WB output register with bubble forcing, reused by other stage boundaries.
- FSM, hold registers and timeout counter stay in ma_stage.

Test Plan:
- ALU op with AluResult=32'h0000_0010, Rd=3, IsWb=1 → next cycle Out_Valid=1, IsWb=1, Rd=3, AluResult=0x10; In_Ready stays 1.
- Load from address 0x100, memory acks after 3 cycles with RData=0xCAFEF00D → Mem_Req high for 3 cycles, Mem_Addr=0x100, In_Ready low; then Out_Valid=1, IsLd=1, LdResult=0xCAFEF00D.
- Store Op2=0x12345678 to 0x204 → Mem_We=1, WData=0x12345678; on completion Out_Valid=1, IsWb=0 passthrough, LdResult=0.
- No ack for 16 cycles → Mem_Req drops after cycle 16, Mem_Err=1, Out_Valid=1 with IsWb=0, LdResult=0.
- Load to 0x102 → Mem_Addr=0x100, Mem_Err=1.
- Rst_n=0 during WAIT, then a late Mem_Ack → next cycle all outputs 0, state IDLE, the late ack causes no Out_Valid.
- Load completes, an ALU op is accepted in DONE → the two results appear on consecutive cycles with no bubble between them.

Source files
------------

// File: rtl/ma_stage_pkg.sv
// Shared core definitions for the memory-access stage and its MA/WB latch.
package ma_stage_pkg;
  localparam int WORD_W     = 32;
  localparam int REG_ADDR_W = 4;
  localparam logic [REG_ADDR_W-1:0] LINK_REG = 4'd15;

  typedef enum logic [1:0] {IDLE, WAIT, DONE} maState_e;

  // Fields carried across the MA/WB boundary.
  typedef struct packed {
    logic                  isWb;
    logic                  isCall;
    logic                  isLd;
    logic [REG_ADDR_W-1:0] rd;
    logic [WORD_W-1:0]     aluResult;
    logic [WORD_W-1:0]     ldResult;
    logic [WORD_W-1:0]     pc;
  } maLatch_t;
endpackage

// File: rtl/ma_stage_if.sv
// Data-memory req/ack port; master is the pipeline stage, slave is the memory.
interface ma_stage_if;
  import ma_stage_pkg::*;
  logic              Mem_Req;
  logic              Mem_We;
  logic [WORD_W-1:0] Mem_Addr;
  logic [WORD_W-1:0] Mem_WData;
  logic              Mem_Ack;
  logic [WORD_W-1:0] Mem_RData;

  modport master (output Mem_Req, Mem_We, Mem_Addr, Mem_WData, input Mem_Ack, Mem_RData);
  modport slave  (input Mem_Req, Mem_We, Mem_Addr, Mem_WData, output Mem_Ack, Mem_RData);
endinterface

// File: rtl/ma_wb_latch.sv
// Pipeline boundary register; control bits are zeroed on a bubble so WB never writes.
module ma_wb_latch
  import ma_stage_pkg::*;
(
  input  logic     Clk,
  input  logic     Rst_n,
  input  logic     inValid,
  input  maLatch_t inData,
  output logic     outValid,
  output maLatch_t outData
);
  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      outValid <= 1'b0;
      outData  <= '0;
    end else begin
      outValid <= inValid;
      outData  <= inData;
      if (!inValid) begin
        outData.isWb   <= 1'b0;
        outData.isCall <= 1'b0;
        outData.isLd   <= 1'b0;
      end
    end
  end
endmodule

// File: rtl/ma_stage.sv
// Memory-access stage: ALU ops pass in one cycle, loads/stores hold the stage
// until the memory acks or the wait counter expires.
module ma_stage
  import ma_stage_pkg::*;
#(
  parameter int unsigned       MEM_TIMEOUT = 16,
  parameter logic [WORD_W-1:0] ERR_LDDATA  = '0
) (
  input  logic                  Clk,
  input  logic                  Rst_n,
  input  logic                  In_Valid,
  output logic                  In_Ready,
  input  logic                  In_IsLd,
  input  logic                  In_IsSt,
  input  logic                  In_IsWb,
  input  logic                  In_IsCall,
  input  logic [REG_ADDR_W-1:0] In_Rd,
  input  logic [WORD_W-1:0]     In_AluResult,
  input  logic [WORD_W-1:0]     In_Op2,
  input  logic [WORD_W-1:0]     In_Pc,
  ma_stage_if.master            mem,
  output logic                  Out_Valid,
  output logic                  IsWb,
  output logic                  IsCall,
  output logic                  IsLd,
  output logic [REG_ADDR_W-1:0] Rd,
  output logic [WORD_W-1:0]     AluResult,
  output logic [WORD_W-1:0]     LdResult,
  output logic [WORD_W-1:0]     pc_current,
  output logic                  Mem_Err
);
  localparam logic [7:0] TO_LAST = 8'(MEM_TIMEOUT - 1);

  maState_e          state, stateNxt;
  maLatch_t          hold, inFields, latchD, latchQ;
  logic              holdSt;
  logic [WORD_W-1:0] holdOp2;
  logic [7:0]        waitCnt;
  logic              memErr, latchV, isMem, accept, toHit;

  assign isMem  = In_IsLd | In_IsSt;
  assign accept = In_Ready & In_Valid;
  assign toHit  = (waitCnt == TO_LAST);

  always_comb begin
    inFields           = '0;
    inFields.isWb      = In_IsWb;
    inFields.isCall    = In_IsCall;
    inFields.isLd      = In_IsLd;
    inFields.rd        = In_Rd;
    inFields.aluResult = In_AluResult;
    inFields.pc        = In_Pc;
  end

  // DONE shares IDLE's accept rules; the held result is already in the latch.
  always_comb begin
    stateNxt = state;
    In_Ready = 1'b0;
    latchV   = 1'b0;
    latchD   = inFields;
    case (state)
      IDLE, DONE: begin
        In_Ready = 1'b1;
        latchV   = In_Valid & ~isMem;
        stateNxt = (In_Valid && isMem) ? WAIT : IDLE;
      end
      WAIT: begin
        if (mem.Mem_Ack) begin
          stateNxt        = DONE;
          latchV          = 1'b1;
          latchD          = hold;
          latchD.ldResult = hold.isLd ? mem.Mem_RData : '0;
        end else if (toHit) begin
          stateNxt        = DONE;
          latchV          = 1'b1;
          latchD          = hold;
          latchD.isWb     = 1'b0;
          latchD.ldResult = ERR_LDDATA;
        end
      end
      default: stateNxt = IDLE;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Rst_n) begin
      state   <= IDLE;
      hold    <= '0;
      holdSt  <= 1'b0;
      holdOp2 <= '0;
      waitCnt <= '0;
      memErr  <= 1'b0;
    end else begin
      state <= stateNxt;
      if (accept && isMem) begin
        hold    <= inFields;
        holdSt  <= In_IsSt & ~In_IsLd;
        holdOp2 <= In_Op2;
        waitCnt <= '0;
        if (In_AluResult[1:0] != 2'b00) memErr <= 1'b1;
      end else if (state == WAIT) begin
        waitCnt <= waitCnt + 8'd1;
      end
      if (state == WAIT && !mem.Mem_Ack && toHit) memErr <= 1'b1;
    end
  end

  assign mem.Mem_Req   = (state == WAIT);
  assign mem.Mem_We    = (state == WAIT) & holdSt;
  assign mem.Mem_Addr  = {hold.aluResult[WORD_W-1:2], 2'b00};
  assign mem.Mem_WData = holdOp2;
  assign Mem_Err       = memErr;

  ma_wb_latch uLatch (
    .Clk     (Clk),
    .Rst_n   (Rst_n),
    .inValid (latchV),
    .inData  (latchD),
    .outValid(Out_Valid),
    .outData (latchQ)
  );

  assign IsWb       = latchQ.isWb;
  assign IsCall     = latchQ.isCall;
  assign IsLd       = latchQ.isLd;
  assign Rd         = latchQ.rd;
  assign AluResult  = latchQ.aluResult;
  assign LdResult   = latchQ.ldResult;
  assign pc_current = latchQ.pc;
endmodule
